// File: rtl/dm_eeprom_copy_ctrl.sv
// Copies a byte string from the shared 64x32 data memory into an I2C EEPROM
// using page writes, driving a command-level I2C byte master via valid/ready.
module dm_eeprom_copy_ctrl #(
  parameter int unsigned PAGE_BYTES = 16,
  parameter int unsigned WR_WAIT    = 5000,
  parameter logic [6:0]  DEV_ADDR   = 7'h50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [31:0] src_addr,
  input  logic [15:0] ee_addr,
  input  logic [8:0]  byte_cnt,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  output logic        dm_write,
  input  logic [31:0] dm_out,
  output logic        i2c_valid,
  output logic [1:0]  i2c_cmd,
  output logic [7:0]  i2c_data,
  input  logic        i2c_ready,
  input  logic        i2c_nack,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned PB_W = $clog2(PAGE_BYTES);

  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_DATA  = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_START, S_AHI, S_ALO, S_DATA, S_STOP, S_WAIT, S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [15:0] cur_ee_q, cur_ee_d;
  logic [8:0]  rem_q, rem_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] wait_q, wait_d;
  logic        err_q, err_d;
  logic        open_q, open_d;
  logic        nacked_q, nacked_d;

  logic        hs;
  logic [15:0] ee_inc;
  logic [8:0]  rem_dec;
  logic [1:0]  off_inc;
  logic [7:0]  buf_byte;

  // CPU always wins the shared memory port; the controller only ever reads.
  assign dm_addr  = cpu_req ? cpu_addr : fetch_addr_q;
  assign dm_din   = cpu_din;
  assign dm_write = cpu_req & cpu_write;

  assign i2c_valid = (state_q == S_START) || (state_q == S_AHI) ||
                     (state_q == S_ALO)   || (state_q == S_DATA) ||
                     (state_q == S_STOP);
  assign hs        = i2c_valid & i2c_ready;
  assign busy      = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done      = (state_q == S_FIN);
  assign err       = err_q;

  assign ee_inc  = cur_ee_q + 16'd1;
  assign rem_dec = rem_q - 9'd1;
  assign off_inc = off_q + 2'd1;

  always_comb begin
    buf_byte = buf_q[31:24];
    case (off_q)
      2'd0: buf_byte = buf_q[31:24];
      2'd1: buf_byte = buf_q[23:16];
      2'd2: buf_byte = buf_q[15:8];
      2'd3: buf_byte = buf_q[7:0];
      default: buf_byte = buf_q[31:24];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    cur_ee_d     = cur_ee_q;
    rem_d        = rem_q;
    off_d        = off_q;
    buf_d        = buf_q;
    wait_d       = wait_q;
    err_d        = err_q;
    open_d       = open_q;
    nacked_d     = nacked_q;
    i2c_cmd      = 2'b00;
    i2c_data     = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          fetch_addr_d = src_addr;
          cur_ee_d     = ee_addr;
          rem_d        = byte_cnt;
          off_d        = 2'd0;
          err_d        = 1'b0;
          open_d       = 1'b0;
          nacked_d     = 1'b0;
          state_d      = (byte_cnt == 9'd0) ? S_FIN : S_FETCH;
        end
      end

      S_FETCH: begin
        if (!cpu_req) begin
          buf_d        = dm_out;
          fetch_addr_d = {fetch_addr_q[31:8], fetch_addr_q[7:0] + 8'd4};
          state_d      = open_q ? S_DATA : S_START;
        end
      end

      S_START: begin
        i2c_cmd  = CMD_START;
        i2c_data = {DEV_ADDR, 1'b0};
        if (hs) begin
          open_d = 1'b1;
          if (i2c_nack) begin
            err_d    = 1'b1;
            nacked_d = 1'b1;
            state_d  = S_STOP;
          end else begin
            state_d  = S_AHI;
          end
        end
      end

      S_AHI: begin
        i2c_cmd  = CMD_DATA;
        i2c_data = cur_ee_q[15:8];
        if (hs) begin
          if (i2c_nack) begin
            err_d    = 1'b1;
            nacked_d = 1'b1;
            state_d  = S_STOP;
          end else begin
            state_d  = S_ALO;
          end
        end
      end

      S_ALO: begin
        i2c_cmd  = CMD_DATA;
        i2c_data = cur_ee_q[7:0];
        if (hs) begin
          if (i2c_nack) begin
            err_d    = 1'b1;
            nacked_d = 1'b1;
            state_d  = S_STOP;
          end else begin
            state_d  = S_DATA;
          end
        end
      end

      S_DATA: begin
        i2c_cmd  = CMD_DATA;
        i2c_data = buf_byte;
        if (hs) begin
          if (i2c_nack) begin
            err_d    = 1'b1;
            nacked_d = 1'b1;
            state_d  = S_STOP;
          end else begin
            cur_ee_d = ee_inc;
            rem_d    = rem_dec;
            off_d    = off_inc;
            // Closing the page takes precedence over refilling the buffer.
            if ((rem_dec == 9'd0) || (ee_inc[PB_W-1:0] == '0)) begin
              state_d = S_STOP;
            end else if (off_inc == 2'd0) begin
              state_d = S_FETCH;
            end
          end
        end
      end

      S_STOP: begin
        i2c_cmd = CMD_STOP;
        if (hs) begin
          open_d = 1'b0;
          if (nacked_q) begin
            state_d = S_FIN;
          end else begin
            wait_d  = WR_WAIT;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (wait_q != '0) begin
          wait_d = wait_q - 32'd1;
        end else if (rem_q == 9'd0) begin
          state_d = S_FIN;
        end else if (off_q == 2'd0) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_START;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fetch_addr_q <= '0;
      cur_ee_q     <= '0;
      rem_q        <= '0;
      off_q        <= '0;
      buf_q        <= '0;
      wait_q       <= '0;
      err_q        <= 1'b0;
      open_q       <= 1'b0;
      nacked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      cur_ee_q     <= cur_ee_d;
      rem_q        <= rem_d;
      off_q        <= off_d;
      buf_q        <= buf_d;
      wait_q       <= wait_d;
      err_q        <= err_d;
      open_q       <= open_d;
      nacked_q     <= nacked_d;
    end
  end

endmodule

// File: tb/tb_dm_eeprom_copy_ctrl.sv
// Bench for dm_eeprom_copy_ctrl: expected I2C command streams are derived from
// byte addresses and page boundaries, independent of the controller's sequencing.
module tb_dm_eeprom_copy_ctrl;

  localparam int unsigned PAGE = 16;
  localparam int unsigned WRW  = 20;
  localparam logic [6:0]  DEV  = 7'h50;
  localparam int          LIMIT = 8000;

  logic        clk, rst, go;
  logic [31:0] src_addr;
  logic [15:0] ee_addr;
  logic [8:0]  byte_cnt;
  logic        cpu_req, cpu_write;
  logic [31:0] cpu_addr, cpu_din;
  logic [31:0] dm_addr, dm_din, dm_out;
  logic        dm_write;
  logic        i2c_valid, i2c_ready, i2c_nack;
  logic [1:0]  i2c_cmd;
  logic [7:0]  i2c_data;
  logic        busy, done, err;

  dm_eeprom_copy_ctrl #(.PAGE_BYTES(PAGE), .WR_WAIT(WRW), .DEV_ADDR(DEV)) dut (
    .clk(clk), .rst(rst), .go(go), .src_addr(src_addr), .ee_addr(ee_addr),
    .byte_cnt(byte_cnt), .cpu_req(cpu_req), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .dm_addr(dm_addr), .dm_din(dm_din),
    .dm_write(dm_write), .dm_out(dm_out), .i2c_valid(i2c_valid),
    .i2c_cmd(i2c_cmd), .i2c_data(i2c_data), .i2c_ready(i2c_ready),
    .i2c_nack(i2c_nack), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Data memory: bench image img is reloaded into ram on request.
  logic [31:0] img [64];
  logic [31:0] ram [64];
  logic        reload = 1'b0;
  assign dm_out = ram[dm_addr[7:2]];
  always @(posedge clk) begin
    if (reload) begin
      for (int k = 0; k < 64; k++) ram[k] <= img[k];
    end else if (dm_write) begin
      ram[dm_addr[7:2]] <= dm_din;
    end
  end

  task automatic load_ram();
    @(posedge clk); #1 reload = 1'b1;
    @(posedge clk); #1 reload = 1'b0;
  endtask

  // Reference model: expected accepted commands as {cmd, data}.
  logic [9:0] exp_q [$];
  int m_idx, m_nack;
  bit exp_err;

  function automatic bit mpush(input logic [1:0] c, input logic [7:0] d);
    bit hit;
    exp_q.push_back({c, d});
    hit = (c != 2'd3) && (m_idx == m_nack);
    m_idx++;
    return hit;
  endfunction

  task automatic build_model(input logic [31:0] src, input logic [15:0] ee,
                             input logic [8:0] cnt, input int nack_at);
    logic [15:0] ea;
    logic [31:0] w;
    logic [7:0]  b;
    int widx;
    bit nk;
    exp_q.delete();
    m_idx = 0; m_nack = nack_at; nk = 0;
    for (int i = 0; i < int'(cnt); i++) begin
      ea = ee + 16'(i);
      if (i == 0 || (int'(ea) % PAGE) == 0) begin
        if (i != 0) void'(mpush(2'd3, 8'h00));
        if (mpush(2'd1, {DEV, 1'b0})) begin nk = 1; break; end
        if (mpush(2'd2, ea[15:8]))    begin nk = 1; break; end
        if (mpush(2'd2, ea[7:0]))     begin nk = 1; break; end
      end
      widx = (int'(src[7:2]) + i / 4) % 64;
      w = img[widx];
      b = 8'(w >> (8 * (3 - (i % 4))));
      if (mpush(2'd2, b)) begin nk = 1; break; end
    end
    if (cnt != 9'd0) void'(mpush(2'd3, 8'h00));
    exp_err = nk;
  endtask

  // Slave / CPU drivers.
  bit manual = 1'b1;
  int rdy_pct = 70, cpu_pct = 30;
  int acc_cnt = 0, nack_tgt = -1;
  bit bp_mode = 1'b0;
  int bp_at = 4, bp_stall = 0;

  always @(posedge clk) begin
    #1;
    if (!manual) begin
      i2c_ready = ($urandom_range(99) < rdy_pct);
      cpu_req   = ($urandom_range(99) < cpu_pct);
      cpu_write = 1'b0;
      cpu_addr  = $urandom;
      cpu_din   = $urandom;
    end else if (bp_mode) begin
      if (acc_cnt == bp_at && bp_stall < 3) begin
        i2c_ready = 1'b0;
        bp_stall++;
      end else begin
        i2c_ready = 1'b1;
      end
    end
    i2c_nack = (acc_cnt == nack_tgt);
  end

  // Monitor.
  bit mon_en = 1'b0;
  bit stop_seen = 1'b0, nack_seen = 1'b0, prev_done = 1'b0;
  int gap = 0, done_cnt = 0;
  logic [9:0] e;

  always @(negedge clk) begin
    if (mon_en) begin
      check("dm_write", {31'b0, dm_write}, {31'b0, cpu_req & cpu_write});
      if (cpu_req) begin
        check("dm_mux", dm_addr, cpu_addr);
        check("dm_din", dm_din, cpu_din);
      end
      if (stop_seen) begin
        if (i2c_valid || done) begin
          if (nack_seen) check("nack_skip_wait", gap, 0);
          else           check("wr_wait_gap", {31'b0, gap >= WRW}, 1);
          stop_seen = 1'b0;
        end else begin
          gap++;
        end
      end
      if (i2c_valid && !i2c_ready && exp_q.size() > 0)
        check("hold", {22'b0, i2c_cmd, i2c_data}, {22'b0, exp_q[0]});
      if (i2c_valid && i2c_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_cmd", {22'b0, i2c_cmd, i2c_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("cmd", {22'b0, i2c_cmd, i2c_data}, {22'b0, e});
        end
        if (i2c_cmd == 2'd3) begin
          stop_seen = 1'b1;
          gap = 0;
        end else if (i2c_nack) begin
          nack_seen = 1'b1;
        end
        acc_cnt++;
      end
      if (done) begin
        done_cnt++;
        check("done_width", {31'b0, prev_done}, 0);
        check("busy_at_done", {31'b0, busy}, 0);
      end
      prev_done = done;
    end
  end

  int done0;

  task automatic start_xfer(input logic [31:0] src, input logic [15:0] ee,
                            input logic [8:0] cnt, input int nack_at);
    build_model(src, ee, cnt, nack_at);
    @(posedge clk); #1;
    acc_cnt = 0; nack_tgt = nack_at; nack_seen = 0; stop_seen = 0; bp_stall = 0;
    done0 = done_cnt;
    go = 1'b1; src_addr = src; ee_addr = ee; byte_cnt = cnt;
    @(posedge clk); #1;
    go = 1'b0;
    @(negedge clk);
    check("err_clr", {31'b0, err}, 0);
    if (cnt != 9'd0) begin
      check("busy_set", {31'b0, busy}, 1);
    end else begin
      check("zero_done", {31'b0, done}, 1);
      check("zero_valid", {31'b0, i2c_valid}, 0);
    end
  endtask

  task automatic finish_xfer();
    int n = 0;
    while (done_cnt == done0 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("done_once", done_cnt - done0, 1);
    check("err", {31'b0, err}, {31'b0, exp_err});
    check("cmds_left", exp_q.size(), 0);
    check("busy_after", {31'b0, busy}, 0);
    check("valid_after", {31'b0, i2c_valid}, 0);
  endtask

  task automatic manual_ready();
    @(posedge clk); #1;
    manual = 1'b1; bp_mode = 1'b0;
    i2c_ready = 1'b1; cpu_req = 1'b0; cpu_write = 1'b0;
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_busy"},  {31'b0, busy}, 0);
    check({pfx, "_done"},  {31'b0, done}, 0);
    check({pfx, "_err"},   {31'b0, err}, 0);
    check({pfx, "_valid"}, {31'b0, i2c_valid}, 0);
    check({pfx, "_cmd"},   {30'b0, i2c_cmd}, 0);
    check({pfx, "_data"},  {24'b0, i2c_data}, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ee_r;
    logic [8:0]  cnt_r;
    int nk_r, n;
    rst = 1'b1; go = 1'b0; src_addr = '0; ee_addr = '0; byte_cnt = '0;
    cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_din = '0;
    i2c_ready = 1'b0; i2c_nack = 1'b0;
    for (int k = 0; k < 64; k++) img[k] = $urandom;
    img[0] = 32'h436F6D70;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;
    load_ram();
    mon_en = 1'b1;

    // Basic copy and page split (same buffered word, no refetch needed).
    manual_ready();
    start_xfer(32'h0, 16'h0000, 9'd4, -1);
    finish_xfer();
    start_xfer(32'h0, 16'h000E, 9'd4, -1);
    finish_xfer();

    // CPU priority: writes land while the controller stalls in FETCH.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 32'd200; cpu_din = 32'hDEADBEEF;
    start_xfer(32'h10, 16'h0100, 9'd8, -1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("cpu_stall_valid", {31'b0, i2c_valid}, 0);
    end
    @(posedge clk); #1 cpu_req = 1'b0; cpu_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("fetch_after_release", {31'b0, i2c_valid}, 1);
    finish_xfer();
    check("cpu_wr", ram[50], 32'hDEADBEEF);

    // Backpressure on the second data byte.
    bp_mode = 1'b1;
    start_xfer(32'h0, 16'h0020, 9'd4, -1);
    finish_xfer();
    check("bp_stalls", bp_stall, 3);
    bp_mode = 1'b0;

    // NACK on the high address byte, then a clean run clears err.
    start_xfer(32'h0, 16'h0000, 9'd4, 1);
    finish_xfer();
    start_xfer(32'h0, 16'h0000, 9'd4, -1);
    finish_xfer();

    // Zero-length request.
    start_xfer(32'h0, 16'h0000, 9'd0, -1);
    finish_xfer();

    // Reset in the middle of DATA.
    start_xfer(32'h0, 16'h0000, 9'd8, -1);
    n = 0;
    while (acc_cnt < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_data", {31'b0, acc_cnt >= 5}, 1);
    @(posedge clk); #1;
    i2c_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    exp_q.delete();
    stop_seen = 1'b0;
    manual_ready();
    start_xfer(32'h0, 16'h0000, 9'd4, -1);
    finish_xfer();

    // Randomized transfers with random ready, NACK and CPU read traffic.
    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < 64; k++) img[k] = $urandom;
      load_ram();
      case ($urandom_range(2))
        0: ee_r = 16'($urandom);
        1: ee_r = 16'($urandom) | 16'h000D;
        default: ee_r = 16'hFFFA;
      endcase
      cnt_r = ($urandom_range(1) == 0) ? 9'($urandom_range(1, 256)) : 9'($urandom_range(1, 20));
      nk_r  = ($urandom_range(3) == 0) ? int'($urandom_range(0, 30)) : -1;
      @(posedge clk); #1 manual = 1'b0;
      start_xfer($urandom & 32'hFFFF_FFFC, ee_r, cnt_r, nk_r);
      finish_xfer();
    end

    manual_ready();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/dm_eeprom_copy_ctrl.md
Name: dm_eeprom_copy_ctrl

Overview:
Sequencer that copies a byte string from the single-cycle data memory (64 x 32-bit, combinational read) into an external I2C EEPROM, using page writes.
It shares the data memory port with the CPU (CPU has absolute priority) and drives a command-level I2C byte master through a valid/ready handshake.
Typical use: dump a boot message such as "Computer Principles..." from RAM to EEPROM.

Parameters:
PAGE_BYTES, 16, EEPROM page size in bytes; power of 2, 2..64.
WR_WAIT, 5000, clock cycles to wait after each STOP for the EEPROM internal write cycle.
DEV_ADDR, 7'h50, 7-bit EEPROM device address.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
go  in  1  start pulse; sampled only in IDLE
src_addr  in  32  data memory byte address of first byte; bits[1:0] must be 0
ee_addr  in  16  EEPROM start byte address
byte_cnt  in  9  bytes to copy, 1..256; 0 means done immediately
cpu_req  in  1  CPU accesses data memory this cycle
cpu_write  in  1  CPU write enable
cpu_addr  in  32  CPU address
cpu_din  in  32  CPU write data
dm_addr  out  32  to memory address
dm_din  out  32  to memory write data
dm_write  out  1  to memory write enable
dm_out  in  32  memory read data; also the CPU's read data
i2c_valid  out  1  command valid
i2c_cmd  out  2  01 = START + dev address (write), 10 = data byte, 11 = STOP
i2c_data  out  8  byte for START/data commands
i2c_ready  in  1  master accepts command when valid & ready
i2c_nack  in  1  qualifies the accepting cycle of START/data: slave NACKed
busy  out  1  high from go acceptance until done
done  out  1  one-cycle pulse at completion (success or error)
err  out  1  sticky NACK flag; cleared by the next accepted go or by rst

Behaviour:
- Reset: state IDLE; busy = 0, done = 0, err = 0, i2c_valid = 0, i2c_cmd = 0, i2c_data = 0, word buffer = 0.
- Memory mux (combinational):
  - dm_addr = cpu_req ? cpu_addr : fetch_addr.
  - dm_din = cpu_din.
  - dm_write = cpu_req & cpu_write.
  - The controller never writes memory.
- States: IDLE, FETCH, START, AHI, ALO, DATA, STOP, WAIT, FIN.
- IDLE:
  - go = 1 latches src_addr, ee_addr and byte_cnt, clears err, and sets busy.
  - If byte_cnt == 0, go to FIN; otherwise go to FETCH.
- FETCH:
  - If cpu_req = 1, stall (no timeout).
  - Otherwise capture dm_out into the word buffer at the clock edge and advance fetch_addr by 4.
  - Next state is START if no page transaction is open, else DATA.
- START: i2c_cmd = 01, i2c_data = {DEV_ADDR, 1'b0}.
- AHI: i2c_cmd = 10, data = cur_ee[15:8].
- ALO: i2c_cmd = 10, data = cur_ee[7:0].
- DATA:
  - i2c_cmd = 10; data is the current buffer byte, big-endian (offset 0 = buf[31:24], offset 3 = buf[7:0]).
  - On handshake: cur_ee += 1, remaining -= 1, offset += 1 (mod 4).
  - Next state on handshake:
    - remaining == 0, or cur_ee[log2 PAGE_BYTES - 1 : 0] wrapped to 0 → STOP.
    - Else offset wrapped to 0 → FETCH.
    - Else stay in DATA.
- Handshake rules:
  - i2c_valid = 1 in START, AHI, ALO, DATA and STOP.
  - cmd and data are held stable until i2c_ready.
  - Each state advances only on valid & ready.
- NACK:
  - i2c_nack = 1 on a START/AHI/ALO/DATA handshake sets err and goes to STOP.
  - After that STOP, go to FIN; skip WAIT.
- STOP: cmd 11; on handshake, load the wait counter with WR_WAIT and go to WAIT.
- WAIT:
  - Count down to 0.
  - If remaining == 0, go to FIN.
  - Else, if offset == 0, go to FETCH; otherwise go to START, since the buffer still holds unsent bytes.
  - A new page transaction always reissues START, AHI and ALO with the updated cur_ee.
- FIN: done = 1 for exactly one cycle, busy = 0, then IDLE.
- Wrap-around:
  - cur_ee wraps at 16 bits.
  - fetch_addr uses only bits[7:2] at memory and wraps modulo 256.
- rst mid-transfer: immediate return to IDLE with no STOP issued. The I2C master is reset by the same rst.
- go while busy is ignored.

Test Plan:
- Basic copy: ram[0] = 32'h436F6D70, byte_cnt = 4, ee_addr = 0, ready tied 1 → commands START A0, 00, 00, 43, 6F, 6D, 70, STOP; then WR_WAIT cycles; done pulse; err = 0.
- Page split: PAGE_BYTES = 16, ee_addr = 16'h000E, byte_cnt = 4 → STOP after 2 bytes; new START with address 00 10; remaining 2 bytes sent from the same buffered word, no refetch.
- CPU priority: hold cpu_req = 1 for 10 cycles during FETCH → dm_addr = cpu_addr, no capture, CPU write lands in ram; the controller fetches on the first cpu_req = 0 cycle.
- Backpressure: i2c_ready low for 3 cycles on the second data byte → i2c_cmd and i2c_data are stable for all 3 cycles; no byte is skipped or duplicated.
- NACK: assert i2c_nack on the AHI handshake → next command STOP, then done with err = 1, no WAIT; a following go clears err.
- Edge and reset cases:
  - byte_cnt = 0 → done pulse 2 cycles after go, no i2c_valid.
  - rst during DATA → next cycle IDLE, all outputs at reset values.
